// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared, externally registered ALU.
// One operation is in flight at a time; illegal modes are answered locally with an error.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_mode,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_mode,

  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_res,
  output logic             resp_zero,
  output logic             resp_err,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_mode,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero,

  output logic             busy
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StCapt  = 2'd2,
    StResp  = 2'd3
  } state_e;

  state_e           state_q;
  logic             ptr_q;
  logic             grant_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [3:0]       alu_mode_q;
  logic [WIDTH-1:0] resp_res_q;
  logic             resp_zero_q;
  logic             resp_err_q;

  logic             any_req;
  logic             win;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [3:0]       sel_mode;
  logic             sel_legal;
  logic             resp_hs;

  function automatic logic mode_legal(input logic [3:0] m);
    case (m)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: return 1'b1;
      default:                                             return 1'b0;
    endcase
  endfunction

  // win=1 selects requester 1; the pointer only matters under contention.
  always_comb begin
    any_req = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      win = ptr_q;
    end else begin
      win = req1_valid;
    end
    sel_a     = win ? req1_a    : req0_a;
    sel_b     = win ? req1_b    : req0_b;
    sel_mode  = win ? req1_mode : req0_mode;
    sel_legal = mode_legal(sel_mode);
    resp_hs   = (state_q == StResp) && (grant_q ? resp1_ready : resp0_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b0;
      grant_q     <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_mode_q  <= 4'b0000;
      resp_res_q  <= '0;
      resp_zero_q <= 1'b0;
      resp_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            grant_q <= win;
            if (sel_legal) begin
              alu_a_q    <= sel_a;
              alu_b_q    <= sel_b;
              alu_mode_q <= sel_mode;
              state_q    <= StIssue;
            end else begin
              // Illegal ops never reach the ALU; its inputs keep the prior op.
              resp_res_q  <= '0;
              resp_zero_q <= 1'b0;
              resp_err_q  <= 1'b1;
              state_q     <= StResp;
            end
          end
        end
        StIssue: begin
          state_q <= StCapt;
        end
        StCapt: begin
          resp_res_q  <= alu_res;
          resp_zero_q <= alu_zero;
          resp_err_q  <= 1'b0;
          state_q     <= StResp;
        end
        StResp: begin
          if (resp_hs) begin
            ptr_q   <= ~grant_q;
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign req0_ready  = rst_n && (state_q == StIdle) && req0_valid && !win;
  assign req1_ready  = rst_n && (state_q == StIdle) && req1_valid && win;
  assign resp0_valid = (state_q == StResp) && !grant_q;
  assign resp1_valid = (state_q == StResp) && grant_q;
  assign resp_res    = resp_res_q;
  assign resp_zero   = resp_zero_q;
  assign resp_err    = resp_err_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_mode    = alu_mode_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised bench for alu_arbiter with a behavioural ALU stub and a
// transaction-level arbitration/latency model.
module tb_alu_arbiter;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [W-1:0] req_a    [2];
  logic [W-1:0] req_b    [2];
  logic [3:0]   req_mode [2];
  wire  [1:0]   req_ready;
  wire  [1:0]   resp_valid;
  logic [1:0]   resp_ready;
  wire  [W-1:0] resp_res;
  wire          resp_zero;
  wire          resp_err;
  wire  [W-1:0] alu_a;
  wire  [W-1:0] alu_b;
  wire  [3:0]   alu_mode;
  logic [W-1:0] alu_res;
  logic         alu_zero;
  wire          busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int           ptr_m;
  logic [W-1:0] last_a, last_b;
  logic [3:0]   last_mode;
  logic         pend_v [2];
  logic [W-1:0] pend_a [2];
  logic [W-1:0] pend_b [2];
  logic [3:0]   pend_m [2];

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req_valid[0]),
    .req0_ready  (req_ready[0]),
    .req0_a      (req_a[0]),
    .req0_b      (req_b[0]),
    .req0_mode   (req_mode[0]),
    .req1_valid  (req_valid[1]),
    .req1_ready  (req_ready[1]),
    .req1_a      (req_a[1]),
    .req1_b      (req_b[1]),
    .req1_mode   (req_mode[1]),
    .resp0_valid (resp_valid[0]),
    .resp0_ready (resp_ready[0]),
    .resp1_valid (resp_valid[1]),
    .resp1_ready (resp_ready[1]),
    .resp_res    (resp_res),
    .resp_zero   (resp_zero),
    .resp_err    (resp_err),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_mode    (alu_mode),
    .alu_res     (alu_res),
    .alu_zero    (alu_zero),
    .busy        (busy)
  );

  function automatic logic is_legal(input logic [3:0] m);
    return m inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
  endfunction

  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] m);
    case (m)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return (a < b) ? a : b;
      4'b1100: return ~(a | b);
      default: return '0;
    endcase
  endfunction

  // Shared ALU stub: one-cycle registered latency, holds on unknown modes.
  always @(posedge clk) begin
    if (is_legal(alu_mode)) begin
      alu_res  <= ref_alu(alu_a, alu_b, alu_mode);
      alu_zero <= (alu_a == alu_b);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_pend(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] m);
    pend_v[r] = 1'b1;
    pend_a[r] = a;
    pend_b[r] = b;
    pend_m[r] = m;
  endtask

  // One complete transaction; entered and left just after a rising edge.
  task automatic txn(input int bp);
    int           w;
    int           lat;
    logic         legal;
    logic [W-1:0] ea, eb, eres;
    logic [3:0]   em;
    logic         ezero;
    for (int r = 0; r < 2; r++) begin
      req_valid[r] = pend_v[r];
      req_a[r]     = pend_a[r];
      req_b[r]     = pend_b[r];
      req_mode[r]  = pend_m[r];
    end
    w  = (pend_v[0] && pend_v[1]) ? ptr_m : (pend_v[1] ? 1 : 0);
    ea = pend_a[w];
    eb = pend_b[w];
    em = pend_m[w];
    legal = is_legal(em);
    eres  = legal ? ref_alu(ea, eb, em) : '0;
    ezero = legal && (ea == eb);
    lat   = legal ? 3 : 1;

    @(negedge clk);
    check("idle_busy", busy, 0);
    check("grant", req_ready, 2'b01 << w);
    @(posedge clk);
    #1;
    pend_v[w]    = 1'b0;
    req_valid[w] = 1'b0;

    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check("busy", busy, 1);
      check("ready_while_busy", req_ready, 0);
      check("resp_latency", resp_valid, (k == lat) ? (2'b01 << w) : 2'b00);
      if (k == 1 && legal) begin
        check("issue_a", alu_a, ea);
        check("issue_b", alu_b, eb);
        check("issue_mode", alu_mode, em);
      end
      if (k == 1 && !legal) check("illegal_alu_mode_held", alu_mode, last_mode);
    end
    if (legal) begin
      last_a    = ea;
      last_b    = eb;
      last_mode = em;
    end
    check("resp_res", resp_res, eres);
    check("resp_zero", resp_zero, ezero);
    check("resp_err", resp_err, !legal);

    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      check("bp_valid", resp_valid, 2'b01 << w);
      check("bp_res", resp_res, eres);
      check("bp_zero", resp_zero, ezero);
      check("bp_err", resp_err, !legal);
      check("bp_no_grant", req_ready, 0);
      check("bp_alu_hold", {alu_mode, alu_a, alu_b}, {last_mode, last_a, last_b});
    end
    resp_ready[w] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[w] = 1'b0;
    ptr_m = 1 - w;
  endtask

  task automatic rand_fill();
    for (int r = 0; r < 2; r++) begin
      if (!pend_v[r] && $urandom_range(0, 2) != 0) begin
        logic [W-1:0] a, b;
        logic [3:0]   m;
        a = $urandom();
        b = ($urandom_range(0, 3) == 0) ? a : W'($urandom());
        case ($urandom_range(0, 7))
          0: m = 4'b0000;
          1: m = 4'b0001;
          2: m = 4'b0010;
          3: m = 4'b0110;
          4: m = 4'b0111;
          5: m = 4'b1100;
          default: m = 4'($urandom());
        endcase
        set_pend(r, a, b, m);
      end
    end
    if (!pend_v[0] && !pend_v[1]) set_pend($urandom_range(0, 1), $urandom(), $urandom(), 4'b0010);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    for (int r = 0; r < 2; r++) begin
      req_a[r] = '0; req_b[r] = '0; req_mode[r] = '0;
      pend_v[r] = 1'b0; pend_a[r] = '0; pend_b[r] = '0; pend_m[r] = '0;
    end
    ptr_m = 0; last_a = '0; last_b = '0; last_mode = '0;

    repeat (3) @(posedge clk);
    req_valid = 2'b11;
    @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_resp", {resp_valid, resp_zero, resp_err, resp_res}, 0);
    check("rst_alu", {alu_mode, alu_a, alu_b}, 0);
    req_valid = 2'b00;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contention after reset, then pointer alternation.
    set_pend(0, 32'd9, 32'd4, 4'b0110);
    set_pend(1, 32'hF0, 32'h3C, 4'b0000);
    txn(0);
    txn(0);
    set_pend(0, 32'd5, 32'd3, 4'b0010);
    set_pend(1, 32'd7, 32'd7, 4'b0111);
    txn(0);
    txn(0);
    // Illegal mode on requester 1.
    set_pend(1, 32'h1234, 32'h5678, 4'b0011);
    txn(0);
    // Backpressure with a competing request.
    set_pend(0, 32'hFFFF_FFFF, 32'd1, 4'b0010);
    set_pend(1, 32'hA5A5_0000, 32'h0000_5A5A, 4'b1100);
    txn(10);
    txn(0);

    // Reset during CAPT discards the in-flight op.
    set_pend(1, 32'd10, 32'd20, 4'b0010);
    req_valid[1] = 1'b1; req_a[1] = pend_a[1]; req_b[1] = pend_b[1]; req_mode[1] = pend_m[1];
    @(negedge clk);
    check("mr_grant", req_ready, 2'b10);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    pend_v[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = 2'b11;
    @(posedge clk);
    #1;
    check("mr_busy", busy, 0);
    check("mr_ready", req_ready, 0);
    check("mr_resp", {resp_valid, resp_zero, resp_err, resp_res}, 0);
    check("mr_alu", {alu_mode, alu_a, alu_b}, 0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0; last_a = '0; last_b = '0; last_mode = '0;
    repeat (4) begin
      @(negedge clk);
      check("mr_no_reply", resp_valid, 0);
      check("mr_idle", busy, 0);
    end
    @(posedge clk);
    #1;
    set_pend(0, 32'd100, 32'd1, 4'b0110);
    set_pend(1, 32'd3, 32'd3, 4'b0001);
    txn(0);
    txn(1);

    for (int i = 0; i < 200; i++) begin
      rand_fill();
      txn($urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the operand and result width.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have ports reqN_valid, input, 1, and reqN_ready, output, 1, for N = 0, 1: per-requester operation handshake.
REQ-005 The block SHALL have ports reqN_a and reqN_b, input, WIDTH, and reqN_mode, input, 4, for N = 0, 1: operands and ALU mode.
REQ-006 The block SHALL have ports respN_valid, output, 1, and respN_ready, input, 1, for N = 0, 1: per-requester response handshake.
REQ-007 The block SHALL have port resp_res, output, WIDTH: shared response result.
REQ-008 The block SHALL have ports resp_zero, output, 1 (operands equal), and resp_err, output, 1 (illegal mode).
REQ-009 The block SHALL have ports alu_a and alu_b, output, WIDTH, and alu_mode, output, 4: drive to the shared ALU.
REQ-010 The block SHALL have ports alu_res, input, WIDTH, and alu_zero, input, 1: ALU outputs, registered inside the ALU with 1-cycle latency.
REQ-011 The block SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, ISSUE, CAPT and RESP, encoded in a 2-bit register.
REQ-013 IDLE: if any reqN_valid is high, the block SHALL grant one requester, assert reqN_ready for that requester in the same cycle (combinational), latch its a, b and mode, and go to ISSUE.
REQ-014 The block SHALL assert reqN_ready only in IDLE and only for the granted requester; a non-granted request stays pending unchanged.
REQ-015 Arbitration SHALL be round-robin: a 1-bit priority pointer selects the winner when both requests are valid; a sole valid request always wins.
REQ-016 The priority pointer SHALL flip to the non-served requester on each completed response handshake.
REQ-017 Legal modes SHALL be 0000, 0001, 0010, 0110, 0111 and 1100; any other mode latched in IDLE SHALL skip ISSUE/CAPT, go straight to RESP with resp_res=0, resp_zero=0 and resp_err=1, and never be driven to the ALU.
REQ-018 ISSUE: alu_a, alu_b and alu_mode SHALL equal the latched values (registered, glitch-free); next state SHALL be CAPT.
REQ-019 CAPT: the block SHALL register alu_res into resp_res and alu_zero into resp_zero, clear resp_err, and go to RESP.
REQ-020 Outside ISSUE, alu_a, alu_b and alu_mode SHALL hold their last values, since the ALU holds its output on an unknown mode.
REQ-021 RESP: the block SHALL assert respN_valid for the granted requester only, with resp_res, resp_zero and resp_err stable until handshake.
REQ-022 When respN_ready is high in RESP, the block SHALL complete the handshake and enter IDLE on the next cycle; no new grant occurs in the handshake cycle.
REQ-023 Respvalid SHALL remain high indefinitely while respN_ready is low (backpressure), and new requests SHALL not be granted meanwhile.
REQ-024 For a legal op, respN_valid SHALL rise exactly 3 cycles after the request handshake edge (T+1 ISSUE, T+2 CAPT, T+3 RESP); for an illegal op, 1 cycle after.
REQ-025 Arithmetic SHALL be performed entirely by the ALU; the block SHALL not modify the width or value of operands or result.

Reset
REQ-026 When rst_n=0 at a clock edge, the block SHALL set state=IDLE, pointer=0 (requester 0 favoured), respN_valid=0, busy=0, resp_res=0, resp_zero=0, resp_err=0, alu_a=0, alu_b=0 and alu_mode=0000.
REQ-027 A reset mid-operation SHALL discard the in-flight op without producing a response; a requester whose request was already accepted SHALL not receive a reply.
REQ-028 While rst_n=0, all reqN_ready outputs SHALL be 0.

Verification
REQ-029 Single op: req0 a=5, b=3, mode=0010 -> resp0_valid at T+3, resp_res=8, resp_zero=0, resp_err=0.
REQ-030 Contention after reset: both valid, req0 mode=0110 (9-4), req1 mode=0000 (F0&3C) -> req0 served first with 5, then req1 with 0x30; both valid again -> req0 served, since the pointer alternates.
REQ-031 Zero/min: a=b=7, mode=0111 -> resp_res=7, resp_zero=1.
REQ-032 Illegal mode 0011 on req1 -> resp1_valid at T+1, resp_err=1, resp_res=0, alu_mode unchanged from the prior op.
REQ-033 Backpressure: resp0_ready held low 10 cycles -> resp0_valid and data stable, req1 not granted until the cycle after handshake.
REQ-034 rst_n low during CAPT -> next cycle IDLE, no respN_valid, pointer=0, outputs at reset values.
